// File: rtl/photo_sensor_pkg.sv
// Shared constants and helpers for the photoresistor input path.
// Used by photo_sensor_array, photo_debounce_chan and the steering FSM.
package photo_sensor_pkg;

    // Raw input level that means "light" for the given polarity.
    function automatic logic light_level(input int active_low);
        return (active_low != 0);
    endfunction

    // Debounce counter width: clog2 with a 1-bit floor.
    function automatic int cnt_width(input int cycles);
        return (cycles > 1) ? $clog2(cycles) : 1;
    endfunction

    // All-ones saturation value for a counter of width w (w <= 32).
    function automatic logic [31:0] sat_value(input int w);
        return 32'hFFFF_FFFF >> (32 - w);
    endfunction

endpackage

// File: rtl/photo_debounce_chan.sv
// One sensor channel: 2-flop sync, polarity, debounce, event pulses
// and a saturating dark-event counter.
// Ports: clk, rst_n, light_raw_i (async level), enable_i, clr_events_i,
//        dark_o, dark_rise_o, dark_fall_o, dark_events_o[CNT_W].
module photo_debounce_chan
    import photo_sensor_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 1000,
    parameter int ACTIVE_LOW_IN   = 1,
    parameter int CNT_W           = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             light_raw_i,
    input  logic             enable_i,
    input  logic             clr_events_i,
    output logic             dark_o,
    output logic             dark_rise_o,
    output logic             dark_fall_o,
    output logic [CNT_W-1:0] dark_events_o
);

    localparam logic LIGHT = light_level(ACTIVE_LOW_IN);
    localparam int   CW    = cnt_width(DEBOUNCE_CYCLES);
    localparam logic [CW-1:0] CNT_LAST =
        CW'(DEBOUNCE_CYCLES - 1);
    localparam logic [CNT_W-1:0] EV_MAX =
        CNT_W'(sat_value(CNT_W));

    logic             s1_q, s2_q;
    logic             raw_dark;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             dark_q, dark_d;
    logic             rise_q, rise_d;
    logic             fall_q, fall_d;
    logic [CNT_W-1:0] ev_q, ev_d;

    // Synchronised level XOR the light level gives "dark".
    assign raw_dark = s2_q ^ LIGHT;

    always_comb begin
        cnt_d  = '0;
        dark_d = dark_q;
        rise_d = 1'b0;
        fall_d = 1'b0;
        if (enable_i && (raw_dark != dark_q)) begin
            if (cnt_q == CNT_LAST) begin
                dark_d = ~dark_q;
                rise_d = ~dark_q;
                fall_d = dark_q;
            end else begin
                cnt_d = cnt_q + CW'(1);
            end
        end
    end

    // A clear that lands on a rise pulse keeps that rise.
    always_comb begin
        ev_d = ev_q;
        if (clr_events_i) begin
            ev_d = CNT_W'(rise_q);
        end else if (rise_q && (ev_q != EV_MAX)) begin
            ev_d = ev_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_q   <= LIGHT;
            s2_q   <= LIGHT;
            cnt_q  <= '0;
            dark_q <= 1'b0;
            rise_q <= 1'b0;
            fall_q <= 1'b0;
            ev_q   <= '0;
        end else begin
            s1_q   <= light_raw_i;
            s2_q   <= s1_q;
            cnt_q  <= cnt_d;
            dark_q <= dark_d;
            rise_q <= rise_d;
            fall_q <= fall_d;
            ev_q   <= ev_d;
        end
    end

    assign dark_o        = dark_q;
    assign dark_rise_o   = rise_q;
    assign dark_fall_o   = fall_q;
    assign dark_events_o = ev_q;

endmodule

// File: rtl/photo_sensor_array.sv
// Multi-channel photoresistor conditioner feeding the steering FSM.
// Ports: clk, rst_n, light_raw, enable, clr_events, dark, dark_rise,
//        dark_fall, any_dark, all_dark, dark_events[CHANNELS*CNT_W].
module photo_sensor_array
    import photo_sensor_pkg::*;
#(
    parameter int CHANNELS        = 4,
    parameter int DEBOUNCE_CYCLES = 1000,
    parameter int ACTIVE_LOW_IN   = 1,
    parameter int CNT_W           = 8
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [CHANNELS-1:0]       light_raw,
    input  logic                      enable,
    input  logic                      clr_events,
    output logic [CHANNELS-1:0]       dark,
    output logic [CHANNELS-1:0]       dark_rise,
    output logic [CHANNELS-1:0]       dark_fall,
    output logic                      any_dark,
    output logic                      all_dark,
    output logic [CHANNELS*CNT_W-1:0] dark_events
);

    for (genvar i = 0; i < CHANNELS; i++) begin : g_chan
        photo_debounce_chan #(
            .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
            .ACTIVE_LOW_IN   (ACTIVE_LOW_IN),
            .CNT_W           (CNT_W)
        ) u_chan (
            .clk           (clk),
            .rst_n         (rst_n),
            .light_raw_i   (light_raw[i]),
            .enable_i      (enable),
            .clr_events_i  (clr_events),
            .dark_o        (dark[i]),
            .dark_rise_o   (dark_rise[i]),
            .dark_fall_o   (dark_fall[i]),
            .dark_events_o (dark_events[i*CNT_W +: CNT_W])
        );
    end

    // Built from registered dark bits only, so glitch-free.
    assign any_dark = |dark;
    assign all_dark = &dark;

endmodule
